// File: rtl/if_fetch_unit_pkg.sv
// ============================================================================
// if_fetch_unit_pkg
// Shared fetch-stage types and constants: fetch state encoding, default reset
// PC and the NOP word that fills the IF/ID register on a bubble.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] c_reset_pc = 32'h0000_3000;
    localparam logic [31:0] c_nop_word = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
// if_fetch_unit
// MIPS instruction-fetch stage: owns the PC, keeps one instruction-memory
// request outstanding and drives the IF/ID register (data, En, clr).
// Build option: DELAY_SLOT_EN keeps the word in flight or held at a redirect.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc8_o,
    output logic [31:0] instr_o,
    output logic        if_id_en_o,
    output logic        if_id_clr_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fpc_q, fpc_d;
    logic [31:0]  hold_instr_q, hold_instr_d;
    logic [31:0]  hold_pc8_q, hold_pc8_d;
    logic         kill_q, kill_d;

    logic         w_req;
    logic         w_deliver;
    logic [31:0]  w_instr;
    logic [31:0]  w_pc8;
    logic [31:0]  w_fpc8;
    logic         w_kill_now;
    logic         w_drop_hold;

    assign w_fpc8 = fpc_q + 32'd8;

`ifdef DELAY_SLOT_EN
    assign w_kill_now  = 1'b0;
    assign w_drop_hold = 1'b0;
`else
    // A redirect in the same cycle as the response kills it just like a registered kill.
    assign w_kill_now  = kill_q | redirect_i;
    assign w_drop_hold = redirect_i;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fpc_d        = fpc_q;
        hold_instr_d = hold_instr_q;
        hold_pc8_d   = hold_pc8_q;
        kill_d       = kill_q;
        w_req        = 1'b0;
        w_deliver    = 1'b0;
        w_instr      = c_nop_word;
        w_pc8        = 32'h0000_0000;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                end else begin
                    w_req   = 1'b1;
                    fpc_d   = pc_q;
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
`ifndef DELAY_SLOT_EN
                    kill_d = 1'b1;
`endif
                end
                if (imem_rvalid_i) begin
                    if (w_kill_now) begin
                        kill_d  = 1'b0;
                        state_d = ST_ISSUE;
                    end else if (!stall_i) begin
                        w_deliver = 1'b1;
                        w_instr   = imem_rdata_i;
                        w_pc8     = w_fpc8;
                        state_d   = ST_ISSUE;
                    end else begin
                        hold_instr_d = imem_rdata_i;
                        hold_pc8_d   = w_fpc8;
                        state_d      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                end
                if (!stall_i) begin
                    state_d = ST_ISSUE;
                    if (!w_drop_hold) begin
                        w_deliver = 1'b1;
                        w_instr   = hold_instr_q;
                        w_pc8     = hold_pc8_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            fpc_q        <= 32'h0000_0000;
            hold_instr_q <= 32'h0000_0000;
            hold_pc8_q   <= 32'h0000_0000;
            kill_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fpc_q        <= fpc_d;
            hold_instr_q <= hold_instr_d;
            hold_pc8_q   <= hold_pc8_d;
            kill_q       <= kill_d;
        end
    end

    // Outputs are forced low in reset; IF/ID clears on its own reset.
    assign imem_req_o  = !reset && w_req;
    assign imem_addr_o = (!reset && state_q == ST_ISSUE) ? pc_q : 32'h0000_0000;
    assign if_id_en_o  = !reset && w_deliver;
    assign if_id_clr_o = !reset && !stall_i && !w_deliver;
    assign instr_o     = reset ? c_nop_word : w_instr;
    assign pc8_o       = reset ? 32'h0000_0000 : w_pc8;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// tb_if_fetch_unit
// Random stall/redirect/latency/reset stimulus on two fetch units (default and
// wrapping reset PC) checked cycle by cycle against a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;

    localparam int N_CYC = 3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        rvalid_i;
    logic [31:0] rdata_i [2];
    logic        req_o   [2];
    logic [31:0] addr_o  [2];
    logic [31:0] pc8_o   [2];
    logic [31:0] instr_o [2];
    logic        en_o    [2];
    logic        clr_o   [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    always #5 clk = ~clk;

    if_fetch_unit u_dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_req_o(req_o[0]), .imem_addr_o(addr_o[0]),
        .imem_rvalid_i(rvalid_i), .imem_rdata_i(rdata_i[0]), .pc8_o(pc8_o[0]),
        .instr_o(instr_o[0]), .if_id_en_o(en_o[0]), .if_id_clr_o(clr_o[0])
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .reset(reset), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_req_o(req_o[1]), .imem_addr_o(addr_o[1]),
        .imem_rvalid_i(rvalid_i), .imem_rdata_i(rdata_i[1]), .pc8_o(pc8_o[1]),
        .instr_o(instr_o[1]), .if_id_en_o(en_o[1]), .if_id_clr_o(clr_o[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Model: fetch address stream, one outstanding fetch, optional held word.
    logic [31:0] rpc [2];
    logic [31:0] m_pc [2];
    logic [31:0] m_faddr [2];
    logic [31:0] mem_addr [2];
    bit m_idle, m_inf, m_kill, m_held;
    bit ds;
    bit mem_pend;
    int mem_due;
    int stall_left;

    initial begin
        bit e_req, e_en;
        bit drop;
`ifdef DELAY_SLOT_EN
        ds = 1'b1;
`else
        ds = 1'b0;
`endif
        rpc[0] = 32'h0000_3000;
        rpc[1] = 32'hFFFF_FFFC;
        reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        rvalid_i = 1'b0; rdata_i[0] = '0; rdata_i[1] = '0;
        m_idle = 1'b1; m_inf = 1'b0; m_kill = 1'b0; m_held = 1'b0;
        mem_pend = 1'b0; mem_due = 0; stall_left = 0;
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = rpc[k]; m_faddr[k] = '0; mem_addr[k] = '0;
        end

        for (cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge clk);
            #1;
            reset = (cyc < 2) || ((m_inf || m_held) && $urandom_range(99) < 2);
            if (stall_left > 0) begin
                stall_i = 1'b1;
                stall_left--;
            end else if ($urandom_range(99) < 20) begin
                stall_i = 1'b1;
                stall_left = $urandom_range(4);
            end else begin
                stall_i = 1'b0;
            end
            redirect_i = !reset && !stall_i && !m_idle && ($urandom_range(99) < 12);
            case ($urandom_range(3))
                0: redirect_pc_i = 32'hFFFF_FFF8;
                1: redirect_pc_i = 32'h0000_4000;
                default: redirect_pc_i = $urandom & 32'hFFFF_FFFC;
            endcase
            rvalid_i = mem_pend && (cyc == mem_due);
            for (int k = 0; k < 2; k++)
                rdata_i[k] = rvalid_i ? memf(mem_addr[k]) : $urandom;
            #4;

            if (reset) begin
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("rst_req%0d", k), {31'd0, req_o[k]}, 32'd0);
                    check($sformatf("rst_addr%0d", k), addr_o[k], 32'd0);
                    check($sformatf("rst_en%0d", k), {31'd0, en_o[k]}, 32'd0);
                    check($sformatf("rst_clr%0d", k), {31'd0, clr_o[k]}, 32'd0);
                    check($sformatf("rst_instr%0d", k), instr_o[k], 32'd0);
                    check($sformatf("rst_pc8%0d", k), pc8_o[k], 32'd0);
                    m_pc[k] = rpc[k];
                end
                m_idle = 1'b1; m_inf = 1'b0; m_kill = 1'b0; m_held = 1'b0;
                mem_pend = 1'b0;
                continue;
            end

            e_req = 1'b0; e_en = 1'b0; drop = 1'b0;
            if (m_idle) begin
                // one dead cycle after reset
            end else if (m_held) begin
                e_en = !stall_i && (ds || !redirect_i);
            end else if (m_inf) begin
                if (rvalid_i) begin
                    drop = m_kill || (redirect_i && !ds);
                    e_en = !drop && !stall_i;
                end
            end else begin
                e_req = !redirect_i;
            end

            for (int k = 0; k < 2; k++) begin
                check($sformatf("req%0d", k), {31'd0, req_o[k]}, {31'd0, e_req});
                if (e_req) check($sformatf("addr%0d", k), addr_o[k], m_pc[k]);
                check($sformatf("en%0d", k), {31'd0, en_o[k]}, {31'd0, e_en});
                check($sformatf("clr%0d", k), {31'd0, clr_o[k]}, {31'd0, !stall_i && !e_en});
                check($sformatf("instr%0d", k), instr_o[k], e_en ? memf(m_faddr[k]) : 32'd0);
                check($sformatf("pc8_%0d", k), pc8_o[k], e_en ? m_faddr[k] + 32'd8 : 32'd0);
                if (e_req) mem_addr[k] = addr_o[k];
            end

            // advance the model
            if (m_idle) begin
                m_idle = 1'b0;
            end else if (m_held) begin
                if (!stall_i) m_held = 1'b0;
                if (redirect_i) for (int k = 0; k < 2; k++) m_pc[k] = redirect_pc_i;
            end else if (m_inf) begin
                if (redirect_i) for (int k = 0; k < 2; k++) m_pc[k] = redirect_pc_i;
                if (rvalid_i) begin
                    m_inf = 1'b0;
                    m_kill = 1'b0;
                    if (!drop && stall_i) m_held = 1'b1;
                end else if (redirect_i && !ds) begin
                    m_kill = 1'b1;
                end
            end else if (redirect_i) begin
                for (int k = 0; k < 2; k++) m_pc[k] = redirect_pc_i;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    m_faddr[k] = m_pc[k];
                    m_pc[k] = m_pc[k] + 32'd4;
                end
                m_inf = 1'b1;
            end

            if (rvalid_i) mem_pend = 1'b0;
            if (e_req) begin
                mem_pend = 1'b1;
                mem_due = cyc + (($urandom_range(2) == 0) ? 1 : int'($urandom_range(4, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
